key_conditioner: RTL

Parametrised N-lane button conditioner sitting between the board push-buttons and the game/judge logic in `top`. It replaces the ad-hoc per-button handling of btnl/btnu/btnr/btnd/btns with one generic block. Per lane it provides:
- synchronisation and debouncing;
- one-cycle press and release pulses;
- long-hold detection.

Lane count, debounce window and hold threshold are parameters.

---
 rtl/key_conditioner.sv | 132 +++++++++++++
 1 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: N-lane push-button conditioner.
// Per lane: two-flop synchroniser, debounce counter, registered press/release
// pulses and, when built with KEY_HOLD_EN, a saturating long-hold detector.
// Without KEY_HOLD_EN no hold counters exist and key_hold_o is tied to 0.
module key_conditioner #(
    parameter int unsigned LANES       = 5,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned HOLD_CYCLES = 50000000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [LANES-1:0] key_i,
    output logic [LANES-1:0] key_level_o,
    output logic [LANES-1:0] key_press_o,
    output logic [LANES-1:0] key_release_o,
    output logic [LANES-1:0] key_hold_o,
    output logic             any_press_o
);

    localparam int unsigned     DebW    = $clog2(DEB_CYCLES + 1);
    localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);

    // Reject degenerate configurations at elaboration time
    if (LANES < 1 || DEB_CYCLES < 1 || HOLD_CYCLES < 1) begin : g_bad_params
        $error("key_conditioner: LANES, DEB_CYCLES and HOLD_CYCLES must be >= 1");
    end

    logic [LANES-1:0] s1_q, s2_q;
    logic [LANES-1:0] level_q, level_d;
    logic [LANES-1:0] press_q, press_d;
    logic [LANES-1:0] release_q, release_d;
    logic             any_press_q;
    logic [DebW-1:0]  deb_cnt_q [LANES];
    logic [DebW-1:0]  deb_cnt_d [LANES];

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= key_i;
            s2_q <= s1_q;
        end
    end

    // Debounce: any agreement cycle restarts the count, so only an unbroken
    // run of DEB_CYCLES disagreeing cycles flips the accepted level
    always_comb begin
        level_d = level_q;
        for (int i = 0; i < LANES; i++) begin
            deb_cnt_d[i] = '0;
            if (s2_q[i] != level_q[i]) begin
                if (deb_cnt_q[i] == DebLast) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;
    end

    // Debounce state and edge pulses, registered in the cycle the level changes
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            level_q     <= '0;
            press_q     <= '0;
            release_q   <= '0;
            any_press_q <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                deb_cnt_q[i] <= '0;
            end
        end else begin
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            any_press_q <= |press_d;
            for (int i = 0; i < LANES; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
        end
    end

`ifdef KEY_HOLD_EN
    localparam int unsigned      HoldW   = $clog2(HOLD_CYCLES + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES);

    logic [HoldW-1:0] hold_cnt_q [LANES];
    logic [HoldW-1:0] hold_cnt_d [LANES];
    logic [LANES-1:0] hold_q, hold_d;

    // Hold count: clears as the level falls so hold drops with the release pulse
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            hold_cnt_d[i] = hold_cnt_q[i];
            if (!level_d[i]) begin
                hold_cnt_d[i] = '0;
            end else if (level_q[i] && hold_cnt_q[i] != HoldMax) begin
                hold_cnt_d[i] = hold_cnt_q[i] + 1'b1;
            end
            hold_d[i] = (hold_cnt_d[i] == HoldMax);
        end
    end

    // Hold counters and registered hold flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q <= '0;
            for (int i = 0; i < LANES; i++) begin
                hold_cnt_q[i] <= '0;
            end
        end else begin
            hold_q <= hold_d;
            for (int i = 0; i < LANES; i++) begin
                hold_cnt_q[i] <= hold_cnt_d[i];
            end
        end
    end

    assign key_hold_o = hold_q;
`else
    assign key_hold_o = '0;
`endif

    assign key_level_o   = level_q;
    assign key_press_o   = press_q;
    assign key_release_o = release_q;
    assign any_press_o   = any_press_q;

endmodule
